// File: rtl/mem_scan_pkg.sv
// Shared types and constants for the main memory scan-chain loader.
package mem_scan_pkg;

  localparam int BYTE_W  = 8;
  localparam int DEF_LEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/scan_serializer.sv
// Byte-to-bit serializer for the memory scan chain (MSB first); with SCAN_READBACK_EN
// it also deserializes scan_out into bytes as they come back from the chain.
module scan_serializer
  import mem_scan_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
`ifdef SCAN_READBACK_EN
  input  logic              scan_out,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              msb,
  output logic              have_byte,
  output logic              bit_last
);

  logic [BYTE_W-1:0] shift_reg;
  logic [2:0]        bit_cnt;

  assign msb      = shift_reg[BYTE_W-1];
  assign bit_last = (bit_cnt == 3'd7);

  // A load may coincide with the shift of the previous byte's last bit; the load wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      have_byte <= 1'b0;
    end else if (clear) begin
      bit_cnt   <= '0;
      have_byte <= 1'b0;
    end else if (load) begin
      shift_reg <= data;
      bit_cnt   <= '0;
      have_byte <= 1'b1;
    end else if (shift) begin
      shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + 3'd1;
      if (bit_last) have_byte <= 1'b0;
    end
  end

`ifdef SCAN_READBACK_EN
  logic [BYTE_W-1:0] rb_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift) begin
        rb_shift <= {rb_shift[BYTE_W-2:0], scan_out};
        if (bit_last) begin
          rb_data  <= {rb_shift[BYTE_W-2:0], scan_out};
          rb_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/mem_scan_loader.sv
// Loads LEN bytes into the main memory scan chain over a valid/ready stream.
// Optional readback of the previous contents is enabled by SCAN_READBACK_EN.
module mem_scan_loader
  import mem_scan_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              scan_in,
  output logic              scan_en,
  input  logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  byte_cnt,
`ifdef SCAN_READBACK_EN
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic [1:0]        state_dbg
);

  // Stream handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready never depends on in_valid; abort suppresses it in the same cycle.

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_t state, state_n;
  logic   have_byte, bit_last, msb;
  logic   transfer, clear, last_shift;

  assign transfer   = in_valid && in_ready;
  assign clear      = (state == IDLE) && start && !abort;
  assign last_shift = scan_en && bit_last && (byte_cnt == LEN_C) && !transfer;
  assign state_dbg  = state;

  scan_serializer u_ser (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (transfer),
    .shift     (scan_en),
    .data      (in_data),
`ifdef SCAN_READBACK_EN
    .scan_out  (scan_out),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
`endif
    .msb       (msb),
    .have_byte (have_byte),
    .bit_last  (bit_last)
  );

`ifndef SCAN_READBACK_EN
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clear) state_n = LOAD;
      LOAD: begin
        if (abort)           state_n = IDLE;
        else if (last_shift) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    in_ready = 1'b0;
    case (state)
      LOAD: begin
        busy     = 1'b1;
        scan_en  = have_byte;
        scan_in  = have_byte & msb;
        in_ready = !abort && (!have_byte || bit_last) && (byte_cnt < LEN_C);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // byte_cnt holds after abort or completion until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      byte_cnt <= '0;
    else if (clear)    byte_cnt <= '0;
    else if (transfer) byte_cnt <= byte_cnt + 1'b1;
  end

endmodule

// File: tb/tb_mem_scan_loader.sv
// Directed bench for mem_scan_loader with a behavioural 512-bit scan-chain memory.
module tb_mem_scan_loader;

  localparam int LEN = 64;

  logic       clk, reset_n, start, abort, in_valid, in_ready;
  logic       scan_in, scan_en, scan_out, busy, done;
  logic [7:0] in_data;
  logic [6:0] byte_cnt;
  logic [1:0] state_dbg;
`ifdef SCAN_READBACK_EN
  logic [7:0] rb_data;
  logic       rb_valid;
`endif

  int checks = 0;
  int failures = 0;

  logic [LEN*8-1:0] chain;
  logic             wipe;

  mem_scan_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scan_in   (scan_in),
    .scan_en   (scan_en),
    .scan_out  (scan_out),
    .busy      (busy),
    .done      (done),
    .byte_cnt  (byte_cnt),
`ifdef SCAN_READBACK_EN
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
`endif
    .state_dbg (state_dbg)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign scan_out = chain[LEN*8-1];

  always @(posedge clk) begin
    if (wipe)         chain <= '1;
    else if (scan_en) chain <= {chain[LEN*8-2:0], scan_in};
  end

  task automatic wipe_mem();
    wipe = 1'b1;
    @(negedge clk);
    wipe = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream_bytes(input int n, output int sent);
    sent = 0;
    for (int cyc = 0; cyc < 2000 && sent < n; cyc++) begin
      in_valid = 1'b1;
      in_data  = 8'(LEN - 1 - sent);
      #1;
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_load(input int stall_len, input bit hold_valid, input bit start_mid,
                          output int en_cnt, output int en_gap, output int done_cnt,
                          output int extra_xfer);
    int sent, stall_left, first_en, last_en;
    bit seen_done, mid_done;
    sent = 0; stall_left = stall_len; en_cnt = 0; first_en = -1; last_en = -1;
    done_cnt = 0; extra_xfer = 0; seen_done = 0; mid_done = 0;
    pulse_start();
    for (int cyc = 0; cyc < 1200 && !seen_done; cyc++) begin
      start = start_mid && (sent == 30) && !mid_done;
      if (start) mid_done = 1'b1;
      #1;
      if (sent == 10 && stall_left > 0 && in_ready) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = (sent < LEN) || hold_valid;
        in_data  = (sent < LEN) ? 8'(LEN - 1 - sent) : 8'hAA;
      end
      #1;
      if (scan_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (done) begin done_cnt++; seen_done = 1'b1; end
      if (in_valid && in_ready) begin
        if (sent < LEN) sent++;
        else            extra_xfer++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done) done_cnt++;
      if (in_valid && in_ready) extra_xfer++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    en_gap = (first_en < 0) ? -1 : (last_en - first_en + 1 - en_cnt);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; wipe = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({scan_in, scan_en, in_ready, busy, done, byte_cnt, state_dbg} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {scan_in, scan_en, in_ready, busy, done, byte_cnt, state_dbg});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release state=%0d busy=%b in_ready=%b exp=0/0/0", state_dbg, busy, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic check_mem(input string name);
    int mism = 0;
    logic [7:0] b;
    for (int a = 0; a < LEN; a++) begin
      b = chain[a*8 +: 8];
      if (b !== 8'(a)) mism++;
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL %s mem_bytes_wrong=%0d exp=0", name, mism);
    end
  endtask

  task automatic test_back_to_back();
    int en_cnt, en_gap, done_cnt, extra;
    wipe_mem();
    run_load(0, 1'b0, 1'b0, en_cnt, en_gap, done_cnt, extra);
    checks++;
    if (en_cnt != 512) begin failures++; $display("FAIL b2b_scan_en_cycles got=%0d exp=512", en_cnt); end
    checks++;
    if (en_gap != 0) begin failures++; $display("FAIL b2b_scan_en_gap got=%0d exp=0", en_gap); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt); end
    check_mem("b2b_memory");
    checks++;
    if (chain[5*8 +: 8] !== 8'h05) begin failures++; $display("FAIL b2b_addr5 got=%h exp=05", chain[5*8 +: 8]); end
    checks++;
    if (chain[6*8 +: 8] !== 8'h06) begin failures++; $display("FAIL b2b_addr6 got=%h exp=06", chain[6*8 +: 8]); end
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL b2b_idle_after busy=%b state=%0d exp=0/0", busy, state_dbg);
    end
  endtask

  task automatic test_stall();
    int en_cnt, en_gap, done_cnt, extra;
    wipe_mem();
    run_load(3, 1'b0, 1'b0, en_cnt, en_gap, done_cnt, extra);
    checks++;
    if (en_gap != 3) begin failures++; $display("FAIL stall_gap got=%0d exp=3", en_gap); end
    checks++;
    if (en_cnt != 512) begin failures++; $display("FAIL stall_scan_en_cycles got=%0d exp=512", en_cnt); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL stall_done_pulses got=%0d exp=1", done_cnt); end
    check_mem("stall_memory");
  endtask

  task automatic test_abort();
    int sent, dcount, en_cnt, en_gap, done_cnt, extra;
    wipe_mem();
    pulse_start();
    stream_bytes(20, sent);
    checks++;
    if (sent != 20) begin failures++; $display("FAIL abort_stream got=%0d exp=20", sent); end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (scan_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs scan_en=%b in_ready=%b busy=%b exp=0/0/0", scan_en, in_ready, busy);
    end
    checks++;
    if (byte_cnt !== 7'd20) begin failures++; $display("FAIL abort_byte_cnt got=%0d exp=20", byte_cnt); end
    dcount = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done || scan_en || in_ready) dcount++;
    end
    in_valid = 1'b0;
    checks++;
    if (dcount != 0) begin failures++; $display("FAIL abort_quiet active_cycles=%0d exp=0", dcount); end
    checks++;
    if (byte_cnt !== 7'd20) begin failures++; $display("FAIL abort_byte_cnt_hold got=%0d exp=20", byte_cnt); end
    @(negedge clk);
    run_load(0, 1'b0, 1'b0, en_cnt, en_gap, done_cnt, extra);
    checks++;
    if (done_cnt != 1 || en_cnt != 512) begin
      failures++;
      $display("FAIL abort_reload done=%0d en=%0d exp=1/512", done_cnt, en_cnt);
    end
    check_mem("abort_reload_memory");
  endtask

  task automatic test_reset_mid_load();
    int sent, bad;
    pulse_start();
    stream_bytes(30, sent);
    checks++;
    if (sent != 30) begin failures++; $display("FAIL rst_mid_stream got=%0d exp=30", sent); end
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({scan_in, scan_en, in_ready, busy, done} !== 5'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=00000", {scan_in, scan_en, in_ready, busy, done});
    end
    checks++;
    if (byte_cnt !== 7'd0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_state byte_cnt=%0d state=%0d exp=0/0", byte_cnt, state_dbg);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (in_ready || scan_en || busy || done || byte_cnt != 7'd0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_mid_idle_ignores active_cycles=%0d exp=0", bad); end
    @(negedge clk);
  endtask

  task automatic test_start_in_load();
    int en_cnt, en_gap, done_cnt, extra;
    wipe_mem();
    run_load(0, 1'b1, 1'b1, en_cnt, en_gap, done_cnt, extra);
    checks++;
    if (extra != 0) begin failures++; $display("FAIL full_in_ready extra_transfers=%0d exp=0", extra); end
    checks++;
    if (done_cnt != 1 || en_cnt != 512) begin
      failures++;
      $display("FAIL start_in_load done=%0d en=%0d exp=1/512", done_cnt, en_cnt);
    end
    checks++;
    if (byte_cnt !== 7'd64) begin failures++; $display("FAIL full_byte_cnt got=%0d exp=64", byte_cnt); end
    check_mem("start_in_load_memory");
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle state=%0d busy=%b exp=0/0", state_dbg, busy);
    end
    @(negedge clk);
    pulse_start();
    #1;
    checks++;
    if (busy !== 1'b1 || byte_cnt !== 7'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_idle busy=%b byte_cnt=%0d in_ready=%b exp=1/0/1", busy, byte_cnt, in_ready);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid_load();
    test_start_in_load();
    test_start_abort_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_scan_loader.md
Name: mem_scan_loader

Overview:
Sequences the main memory scan chain. It accepts a stream of bytes over a valid/ready handshake and serialises each byte MSB-first onto scan_in, holding scan_en high only while a bit is being shifted. After exactly LEN bytes it signals completion. The block sits between the host/boot loader and main_memory, and is the only driver of scan_in and scan_en.

Parameters:
LEN, 64, number of memory bytes in the chain; one load is exactly LEN bytes
CNT_W, 7, byte-counter width; must satisfy 2**CNT_W > LEN

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE
abort  in  1  returns the block to IDLE on the next edge; the memory keeps whatever it holds
in_data  in  8  byte to load; the first byte accepted ends at address LEN-1, the last at address 0
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle (transfer when in_valid && in_ready)
scan_in  out  1  serial data to the memory, equal to shift_reg[7]
scan_en  out  1  shift enable to the memory
scan_out  in  1  serial data from the memory; used only by the optional feature
busy  out  1  high in LOAD
done  out  1  one-cycle pulse when the final bit has shifted
byte_cnt  out  CNT_W  number of bytes accepted in the current load

Behaviour:
- Reset: state IDLE; shift_reg, bit_cnt, byte_cnt and have_byte are cleared. All outputs are 0 while reset_n is low. Reset mid-load abandons the load with no completion pulse.
- FSM states are IDLE, LOAD and DONE.
- IDLE -> LOAD on start. At that edge byte_cnt is cleared and have_byte is cleared.
- In LOAD:
  - in_ready = (!have_byte || bit_cnt==7) && (byte_cnt < LEN).
  - scan_en = have_byte. scan_in = shift_reg[7] whenever have_byte is set, otherwise 0.
- On each edge with scan_en high: shift_reg shifts left by one and bit_cnt increments (wraps 7 -> 0).
- On a transfer, at the same edge: shift_reg <= in_data, bit_cnt <= 0, have_byte <= 1, byte_cnt increments.
- When bit_cnt==7 is shifted without a new transfer: have_byte <= 0.
- Throughput is back-to-back: with in_valid held high, one byte is shifted every 8 cycles and scan_en stays high continuously.
- Latency: a byte accepted at edge k shifts its MSB at edge k+1 and its LSB at edge k+8.
- Stall: if in_valid is low when a byte is needed, scan_en drops and the memory holds. Shifting resumes on the next transfer with no lost or duplicated bits.
- LOAD -> DONE at the edge that shifts bit 7 of byte LEN. DONE lasts one cycle: done=1, busy=0, then the FSM returns to IDLE.
- abort has priority over everything else in LOAD. The FSM goes to IDLE; scan_en and in_ready are 0 from the next cycle; no done pulse.
- start in LOAD or DONE is ignored.
- abort and start together in IDLE: abort wins and the FSM stays in IDLE.
- Once byte_cnt==LEN, in_ready stays 0 even if in_valid is high.

Optional Feature:
Macro SCAN_READBACK_EN.
- When defined, two outputs are added:
  - rb_data [8]: scan_out sampled on every scan_en edge and assembled MSB-first.
  - rb_valid: a one-cycle pulse as each byte completes.
- Readback returns the previous memory contents, address LEN-1 first, interleaved with the load.
- rb_valid pulses exactly LEN times per completed load. Readback has no back-pressure; the consumer must accept every pulse.
- rb_data and rb_valid reset to 0.
- When the macro is undefined, these ports do not exist and scan_out is unused.

Decomposition:
- Shared package mem_scan_pkg holds:
  - the state enum {IDLE, LOAD, DONE};
  - the BYTE_W=8 constant;
  - the default LEN.
- One sub-module, scan_serializer, contains shift_reg, bit_cnt and have_byte, plus the readback deserializer when the macro is enabled.
- The FSM and byte counter stay in the top level.

Test Plan:
- Reset_n low for 2 cycles, then start, then stream bytes 0x3F down to 0x00 with in_valid always high -> scan_en high for exactly 512 consecutive cycles; done pulses once; main_memory address a reads a (addr 5 -> 0x05, addr 6 -> 0x06).
- Same stream with in_valid low for 3 cycles after byte 10 -> scan_en is low for exactly 3 cycles and the final memory contents are identical.
- Abort after 20 bytes -> scan_en is 0 the next cycle; no done; byte_cnt holds at 20; a following start and full load completes normally.
- Reset_n asserted at bit 4 of byte 30 -> all outputs are 0 immediately; after release the FSM is in IDLE and ignores in_valid until start.
- start pulsed during LOAD and in_valid held high after byte 64 -> neither restarts the load; in_ready=0 after the 64th transfer.
- With SCAN_READBACK_EN: preload 0x00..0x3F, then load 0xFF x64 -> rb_data sequence is 0x3F, 0x3E, ..., 0x00 with 64 rb_valid pulses.
